// File: rtl/db_pkg.sv
// Shared definitions for the data burst controller: default widths, bank data range
// and the controller state encoding.
package db_pkg;

   localparam int ADDR_W_DEF    = 9;
   localparam int DATA_W_DEF    = 8;
   localparam int LEN_W_DEF     = 8;
   localparam int BANK_DATA_TOP = 255;

   typedef enum logic [2:0] {
      ST_IDLE   = 3'd0,
      ST_HDR    = 3'd1,
      ST_WBEAT  = 3'd2,
      ST_RBEAT  = 3'd3,
      ST_RFLUSH = 3'd4,
      ST_DONE   = 3'd5
   } state_t;

endpackage

// File: rtl/burst_splitter.sv
// Holds the transfer pointer, remaining byte count and per-burst beat counter, and
// derives the length of the next burst as min(max burst size, remaining).
module burst_splitter
   import db_pkg::*;
#(
   parameter int LEN_W = LEN_W_DEF
)(
   input  logic             clk,
   input  logic             rst_n,
   input  logic             load_i,
   input  logic [LEN_W-1:0] length_i,
   input  logic [LEN_W-1:0] mbs_i,
   input  logic             grant_i,
   input  logic             beat_i,
   output logic [LEN_W-1:0] ptr_o,
   output logic [LEN_W-1:0] rem_o,
   output logic [LEN_W-1:0] beat_cnt_o,
   output logic [LEN_W-1:0] burst_len_o
);

   logic [LEN_W-1:0] mbs_q, mbs_d;
   logic [LEN_W-1:0] ptr_q, ptr_d;
   logic [LEN_W-1:0] rem_q, rem_d;
   logic [LEN_W-1:0] cnt_q, cnt_d;
   logic [LEN_W-1:0] burst_len;

   assign burst_len = (mbs_q < rem_q) ? mbs_q : rem_q;

   always_comb begin
      mbs_d = mbs_q;
      ptr_d = ptr_q;
      rem_d = rem_q;
      cnt_d = cnt_q;
      if (load_i) begin
         // A zero burst size would never make progress, so treat it as single-beat.
         mbs_d = (mbs_i == '0) ? LEN_W'(1) : mbs_i;
         ptr_d = '0;
         rem_d = length_i;
         cnt_d = '0;
      end else if (grant_i) begin
         cnt_d = burst_len;
      end else if (beat_i) begin
         ptr_d = ptr_q + 1'b1;
         rem_d = rem_q - 1'b1;
         cnt_d = cnt_q - 1'b1;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         mbs_q <= '0;
         ptr_q <= '0;
         rem_q <= '0;
         cnt_q <= '0;
      end else begin
         mbs_q <= mbs_d;
         ptr_q <= ptr_d;
         rem_q <= rem_d;
         cnt_q <= cnt_d;
      end
   end

   assign ptr_o       = ptr_q;
   assign rem_o       = rem_q;
   assign beat_cnt_o  = cnt_q;
   assign burst_len_o = burst_len;

endmodule

// File: rtl/data_burst_ctrl.sv
// Moves a block of bytes between register-bank data locations 0..length-1 and an
// external burst interface, splitting it into bursts of at most max_burst_size beats.
//
// Handshakes: a header is accepted on a cycle with bst_req && bst_gnt; a write beat
// moves on a cycle with bst_wvalid && bst_wready, wvalid/wdata/addr held until then;
// read beats have no backpressure and are taken on any bst_rvalid while in RBEAT.
module data_burst_ctrl
   import db_pkg::*;
#(
   parameter int ADDR_W = ADDR_W_DEF,
   parameter int DATA_W = DATA_W_DEF,
   parameter int LEN_W  = LEN_W_DEF
)(
   input  logic              clk,
   input  logic              rst_n,
   input  logic              rb_db_start,
   input  logic [LEN_W-1:0]  rb_db_length,
   input  logic [LEN_W-1:0]  rb_db_max_burst_size,
   input  logic              rb_db_rw,
   input  logic [DATA_W-1:0] rb_db_data,
   input  logic              rb_db_ack,
   output logic              db_rb_req,
   output logic [ADDR_W-1:0] db_rb_addr,
   output logic [DATA_W-1:0] db_rb_data,
   output logic              db_rb_idle,
   output logic              db_rb_rd_done,
   output logic              bst_req,
   input  logic              bst_gnt,
   output logic              bst_rw,
   output logic [LEN_W-1:0]  bst_len,
   output logic              bst_wvalid,
   input  logic              bst_wready,
   output logic [DATA_W-1:0] bst_wdata,
   input  logic              bst_rvalid,
   input  logic [DATA_W-1:0] bst_rdata,
   output state_t            dbg_state
);

   state_t            state_q, state_d;
   logic              rw_q, rw_d;
   logic              rd_req_q;
   logic [LEN_W-1:0]  rd_addr_q;
   logic [DATA_W-1:0] rd_data_q;

   logic              load, grant, beat, rd_cap;
   logic [LEN_W-1:0]  ptr, rem, beat_cnt, burst_len;
   logic              unused_ack;

   assign unused_ack = rb_db_ack;

   burst_splitter #(.LEN_W(LEN_W)) u_splitter (
      .clk         (clk),
      .rst_n       (rst_n),
      .load_i      (load),
      .length_i    (rb_db_length),
      .mbs_i       (rb_db_max_burst_size),
      .grant_i     (grant),
      .beat_i      (beat),
      .ptr_o       (ptr),
      .rem_o       (rem),
      .beat_cnt_o  (beat_cnt),
      .burst_len_o (burst_len)
   );

   always_comb begin
      state_d = state_q;
      load    = 1'b0;
      grant   = 1'b0;
      beat    = 1'b0;
      rd_cap  = 1'b0;
      case (state_q)
         ST_IDLE: begin
            if (rb_db_start) begin
               load    = 1'b1;
               state_d = (rb_db_length == '0) ? ST_DONE : ST_HDR;
            end
         end
         ST_HDR: begin
            if (bst_gnt) begin
               grant   = 1'b1;
               state_d = rw_q ? ST_WBEAT : ST_RBEAT;
            end
         end
         ST_WBEAT: begin
            if (bst_wready) begin
               beat = 1'b1;
               if (beat_cnt == LEN_W'(1))
                  state_d = (rem == LEN_W'(1)) ? ST_DONE : ST_HDR;
            end
         end
         ST_RBEAT: begin
            if (bst_rvalid) begin
               beat   = 1'b1;
               rd_cap = 1'b1;
               // The last bank write is registered, so give it a cycle before DONE.
               if (beat_cnt == LEN_W'(1))
                  state_d = (rem == LEN_W'(1)) ? ST_RFLUSH : ST_HDR;
            end
         end
         ST_RFLUSH: state_d = ST_DONE;
         ST_DONE:   state_d = ST_IDLE;
         default:   state_d = ST_IDLE;
      endcase
   end

   assign rw_d = load ? rb_db_rw : rw_q;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q   <= ST_IDLE;
         rw_q      <= 1'b0;
         rd_req_q  <= 1'b0;
         rd_addr_q <= '0;
         rd_data_q <= '0;
      end else begin
         state_q  <= state_d;
         rw_q     <= rw_d;
         rd_req_q <= rd_cap;
         if (rd_cap) begin
            rd_addr_q <= ptr;
            rd_data_q <= bst_rdata;
         end
      end
   end

   assign db_rb_idle    = (state_q == ST_IDLE);
   assign db_rb_rd_done = (state_q == ST_DONE) && !rw_q;
   assign bst_req       = (state_q == ST_HDR);
   assign bst_rw        = rw_q;
   assign bst_len       = (state_q == ST_HDR) ? burst_len : '0;
   assign bst_wvalid    = (state_q == ST_WBEAT);
   assign bst_wdata     = (state_q == ST_WBEAT) ? rb_db_data : '0;

   // Bank port: live pointer while streaming out, registered pulse while reading in.
   always_comb begin
      db_rb_req  = 1'b0;
      db_rb_addr = '0;
      db_rb_data = '0;
      if (state_q == ST_WBEAT) begin
         db_rb_req  = 1'b1;
         db_rb_addr = {{(ADDR_W-LEN_W){1'b0}}, ptr};
      end else if (rd_req_q) begin
         db_rb_req  = 1'b1;
         db_rb_addr = {{(ADDR_W-LEN_W){1'b0}}, rd_addr_q};
         db_rb_data = rd_data_q;
      end
   end

   assign dbg_state = state_q;

endmodule

// File: tb/tb_data_burst_ctrl.sv
// Directed bench for data_burst_ctrl: a behavioural register bank and burst slave,
// one task per scenario, each with hand-computed expectations.
module tb_data_burst_ctrl;
  import db_pkg::*;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  logic       rb_db_start;
  logic [7:0] rb_db_length, rb_db_max_burst_size;
  logic       rb_db_rw;
  logic [7:0] rb_db_data;
  logic       rb_db_ack;
  logic       db_rb_req;
  logic [8:0] db_rb_addr;
  logic [7:0] db_rb_data;
  logic       db_rb_idle, db_rb_rd_done;
  logic       bst_req, bst_gnt, bst_rw;
  logic [7:0] bst_len;
  logic       bst_wvalid, bst_wready;
  logic [7:0] bst_wdata;
  logic       bst_rvalid;
  logic [7:0] bst_rdata;
  state_t     dbg_state;

  logic [7:0] bank [256];
  assign rb_db_data = bank[db_rb_addr[7:0]];
  assign rb_db_ack  = db_rb_req;

  data_burst_ctrl dut (
    .clk(clk), .rst_n(rst_n),
    .rb_db_start(rb_db_start), .rb_db_length(rb_db_length),
    .rb_db_max_burst_size(rb_db_max_burst_size), .rb_db_rw(rb_db_rw),
    .rb_db_data(rb_db_data), .rb_db_ack(rb_db_ack),
    .db_rb_req(db_rb_req), .db_rb_addr(db_rb_addr), .db_rb_data(db_rb_data),
    .db_rb_idle(db_rb_idle), .db_rb_rd_done(db_rb_rd_done),
    .bst_req(bst_req), .bst_gnt(bst_gnt), .bst_rw(bst_rw), .bst_len(bst_len),
    .bst_wvalid(bst_wvalid), .bst_wready(bst_wready), .bst_wdata(bst_wdata),
    .bst_rvalid(bst_rvalid), .bst_rdata(bst_rdata), .dbg_state(dbg_state)
  );

  // ---------------- scoreboard state ----------------
  int checks = 0;
  int errors = 0;
  logic [7:0] exp_q[$];
  logic [7:0] hdr_log[$], wdata_log[$], rd_src_q[$];
  logic [8:0] waddr_log[$], baddr_log[$];
  int  req_cycles, len_viol, hold_viol, stall_cycles;
  int  rd_done_cnt, rd_done_cyc, rflush_cyc;
  logic first_idle_val;
  bit  timed_out;
  logic wpat [8];
  int  wpat_n;

  // ---------------- driver ----------------
  task automatic run_xfer(input logic rw, input logic [7:0] len, input logic [7:0] mbs,
                          input int gnt_delay, input int start2_at, input int abort_at);
    int pend, req_run, widx;
    logic prev_req, prev_stall, left_idle, fin;
    logic [7:0] held_len, held_wd;
    logic [8:0] held_wa;
    hdr_log.delete(); wdata_log.delete(); waddr_log.delete(); baddr_log.delete();
    req_cycles = 0; len_viol = 0; hold_viol = 0; stall_cycles = 0;
    rd_done_cnt = 0; rd_done_cyc = -1; rflush_cyc = -100; timed_out = 0;
    pend = 0; req_run = 0; widx = 0; prev_req = 0; prev_stall = 0;
    left_idle = 0; fin = 0; held_len = 0; held_wd = 0; held_wa = 0;
    @(negedge clk);
    rb_db_start = 1'b1; rb_db_length = len; rb_db_max_burst_size = mbs; rb_db_rw = rw;
    for (int i = 1; i <= 300 && !fin; i++) begin
      @(negedge clk);
      if (i == 1) begin
        rb_db_start = 1'b0;
        first_idle_val = db_rb_idle;
      end
      if (i == start2_at) begin
        rb_db_start = 1'b1; rb_db_length = 8'd2; rb_db_max_burst_size = 8'd1; rb_db_rw = ~rw;
      end else if (i == start2_at + 1) begin
        rb_db_start = 1'b0;
      end
      // observe
      if (bst_req) begin
        if (!prev_req) begin
          hdr_log.push_back(bst_len);
          held_len = bst_len;
          req_run = 0;
        end else if (bst_len !== held_len) begin
          len_viol++;
        end
        req_cycles++;
      end
      prev_req = bst_req;
      if (db_rb_req && !bst_wvalid) begin
        bank[db_rb_addr[7:0]] = db_rb_data;
        baddr_log.push_back(db_rb_addr);
      end
      if (db_rb_rd_done) begin
        rd_done_cnt++;
        rd_done_cyc = i;
      end
      if (dbg_state == ST_RFLUSH) rflush_cyc = i;
      if (!db_rb_idle) left_idle = 1;
      if (i == abort_at) begin
        rst_n = 1'b0; bst_gnt = 0; bst_wready = 0; bst_rvalid = 0;
        return;
      end
      if (left_idle && db_rb_idle) begin
        fin = 1;
        bst_gnt = 0; bst_wready = 0; bst_rvalid = 0;
      end else begin
        // read beats for an already granted burst
        if (pend > 0 && rd_src_q.size() > 0) begin
          bst_rvalid = 1'b1;
          bst_rdata  = rd_src_q.pop_front();
          pend--;
        end else begin
          bst_rvalid = 1'b0;
        end
        // header grant after the requested delay
        if (bst_req && req_run >= gnt_delay) begin
          bst_gnt = 1'b1;
          if (!rw) pend = int'(bst_len);
        end else begin
          bst_gnt = 1'b0;
        end
        if (bst_req) req_run++;
        // write beats with a ready pattern
        if (bst_wvalid) begin
          if (prev_stall && (bst_wdata !== held_wd || db_rb_addr !== held_wa)) hold_viol++;
          bst_wready = wpat[widx % wpat_n];
          widx++;
          if (bst_wready) begin
            wdata_log.push_back(bst_wdata);
            waddr_log.push_back(db_rb_addr);
            prev_stall = 0;
          end else begin
            prev_stall = 1; held_wd = bst_wdata; held_wa = db_rb_addr; stall_cycles++;
          end
        end else begin
          bst_wready = 1'b0;
          prev_stall = 0;
        end
      end
    end
    if (!fin) timed_out = 1;
  endtask

  // ---------------- scenarios ----------------
  task automatic test_reset();
    rst_n = 1'b0;
    rb_db_start = 0; rb_db_length = 0; rb_db_max_burst_size = 0; rb_db_rw = 0;
    bst_gnt = 0; bst_wready = 0; bst_rvalid = 0; bst_rdata = 0;
    repeat (2) @(negedge clk);
    checks++;
    if ({db_rb_idle, db_rb_req, db_rb_addr, db_rb_data, db_rb_rd_done, bst_req, bst_rw,
         bst_len, bst_wvalid, bst_wdata} !== {1'b1, 38'b0}) begin
      errors++;
      $display("FAIL reset_outputs: got %h expected %h", {db_rb_idle, db_rb_req, db_rb_addr,
               db_rb_data, db_rb_rd_done, bst_req, bst_rw, bst_len, bst_wvalid, bst_wdata},
               {1'b1, 38'b0});
    end
    checks++;
    if (dbg_state !== ST_IDLE) begin
      errors++;
      $display("FAIL reset_state: got %0d expected %0d", dbg_state, ST_IDLE);
    end
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_write_split();
    for (int i = 0; i < 5; i++) bank[i] = 8'hA0 + 8'(i);
    wpat[0] = 1; wpat_n = 1;
    run_xfer(1'b1, 8'd5, 8'd2, 0, 0, 0);
    checks++;
    if (timed_out) begin errors++; $display("FAIL wr_timeout: got timeout expected completion"); end
    checks++;
    if (first_idle_val !== 1'b0) begin
      errors++; $display("FAIL wr_idle_drop: got %b expected 0", first_idle_val);
    end
    exp_q = {8'd2, 8'd2, 8'd1};
    checks++;
    if (hdr_log.size() != exp_q.size()) begin
      errors++; $display("FAIL wr_hdr_count: got %0d expected %0d", hdr_log.size(), exp_q.size());
    end else begin
      foreach (exp_q[k]) begin
        checks++;
        if (hdr_log[k] !== exp_q[k]) begin
          errors++; $display("FAIL wr_hdr_len[%0d]: got %0d expected %0d", k, hdr_log[k], exp_q[k]);
        end
      end
    end
    exp_q = {8'hA0, 8'hA1, 8'hA2, 8'hA3, 8'hA4};
    checks++;
    if (wdata_log.size() != exp_q.size()) begin
      errors++; $display("FAIL wr_beat_count: got %0d expected %0d", wdata_log.size(), exp_q.size());
    end else begin
      foreach (exp_q[k]) begin
        checks++;
        if (wdata_log[k] !== exp_q[k] || waddr_log[k] !== 9'(k)) begin
          errors++;
          $display("FAIL wr_beat[%0d]: got data %h addr %0d expected data %h addr %0d",
                   k, wdata_log[k], waddr_log[k], exp_q[k], k);
        end
      end
    end
    checks++;
    if (rd_done_cnt != 0) begin errors++; $display("FAIL wr_rd_done: got %0d pulses expected 0", rd_done_cnt); end
    checks++;
    if (db_rb_idle !== 1'b1) begin errors++; $display("FAIL wr_idle_back: got %b expected 1", db_rb_idle); end
  endtask

  task automatic test_read_in();
    for (int i = 0; i < 4; i++) bank[i] = 8'hEE;
    rd_src_q = {8'h11, 8'h22, 8'h33, 8'h44};
    run_xfer(1'b0, 8'd4, 8'd4, 0, 0, 0);
    checks++;
    if (timed_out) begin errors++; $display("FAIL rd_timeout: got timeout expected completion"); end
    exp_q = {8'h11, 8'h22, 8'h33, 8'h44};
    foreach (exp_q[k]) begin
      checks++;
      if (bank[k] !== exp_q[k]) begin
        errors++; $display("FAIL rd_bank[%0d]: got %h expected %h", k, bank[k], exp_q[k]);
      end
    end
    checks++;
    if (baddr_log.size() != 4) begin
      errors++; $display("FAIL rd_write_count: got %0d expected 4", baddr_log.size());
    end
    checks++;
    if (hdr_log.size() != 1 || hdr_log[0] !== 8'd4) begin
      errors++; $display("FAIL rd_hdr: got %0d headers expected one of len 4", hdr_log.size());
    end
    checks++;
    if (rd_done_cnt != 1) begin errors++; $display("FAIL rd_done_count: got %0d expected 1", rd_done_cnt); end
    checks++;
    if (rd_done_cyc != rflush_cyc + 1) begin
      errors++; $display("FAIL rd_done_timing: got cycle %0d expected %0d", rd_done_cyc, rflush_cyc + 1);
    end
  endtask

  task automatic test_boundaries();
    run_xfer(1'b0, 8'd0, 8'd4, 0, 0, 0);
    checks++;
    if (hdr_log.size() != 0) begin errors++; $display("FAIL len0_req: got %0d headers expected 0", hdr_log.size()); end
    checks++;
    if (rd_done_cnt != 1 || rd_done_cyc < 1 || rd_done_cyc > 3) begin
      errors++; $display("FAIL len0_rd_done: got %0d pulses at cycle %0d expected 1 within 3", rd_done_cnt, rd_done_cyc);
    end
    for (int i = 0; i < 3; i++) bank[i] = 8'h70 + 8'(i);
    wpat[0] = 1; wpat_n = 1;
    run_xfer(1'b1, 8'd3, 8'd0, 0, 0, 0);
    exp_q = {8'd1, 8'd1, 8'd1};
    checks++;
    if (hdr_log != exp_q) begin
      errors++; $display("FAIL mbs0_hdr: got %0d headers (first len %0d) expected 3 of len 1", hdr_log.size(), hdr_log.size() > 0 ? hdr_log[0] : 8'd0);
    end
    exp_q = {8'h70, 8'h71, 8'h72};
    checks++;
    if (wdata_log != exp_q) begin
      errors++; $display("FAIL mbs0_data: got %0d beats expected 70 71 72", wdata_log.size());
    end
  endtask

  task automatic test_stall_and_gnt_delay();
    for (int i = 0; i < 3; i++) bank[i] = 8'h30 + 8'(i);
    wpat[0] = 1; wpat[1] = 0; wpat[2] = 0; wpat[3] = 1; wpat[4] = 1; wpat_n = 5;
    run_xfer(1'b1, 8'd3, 8'd3, 4, 0, 0);
    checks++;
    if (timed_out) begin errors++; $display("FAIL stall_timeout: got timeout expected completion"); end
    checks++;
    if (req_cycles != 5 || len_viol != 0) begin
      errors++; $display("FAIL gnt_delay_req: got %0d req cycles %0d len changes expected 5 and 0", req_cycles, len_viol);
    end
    checks++;
    if (hdr_log.size() != 1 || hdr_log[0] !== 8'd3) begin
      errors++; $display("FAIL gnt_delay_len: got %0d headers expected one of len 3", hdr_log.size());
    end
    checks++;
    if (stall_cycles != 2 || hold_viol != 0) begin
      errors++; $display("FAIL stall_hold: got %0d stalls %0d changes expected 2 and 0", stall_cycles, hold_viol);
    end
    exp_q = {8'h30, 8'h31, 8'h32};
    checks++;
    if (wdata_log != exp_q) begin
      errors++; $display("FAIL stall_data: got %0d transfers expected 30 31 32", wdata_log.size());
    end
    checks++;
    if (waddr_log.size() != 3 || waddr_log[2] !== 9'd2) begin
      errors++; $display("FAIL stall_addr: got %0d transfers expected last addr 2", waddr_log.size());
    end
  endtask

  task automatic test_restart_and_abort();
    for (int i = 0; i < 8; i++) bank[i] = 8'h5A;
    rd_src_q = {8'hC1, 8'hC2, 8'hC3, 8'hC4, 8'hC5, 8'hC6, 8'hC7, 8'hC8};
    run_xfer(1'b0, 8'd8, 8'd4, 0, 3, 5);
    repeat (2) @(negedge clk);
    checks++;
    if ({db_rb_idle, db_rb_req, db_rb_addr, db_rb_data, db_rb_rd_done, bst_req, bst_rw,
         bst_len, bst_wvalid, bst_wdata} !== {1'b1, 38'b0}) begin
      errors++;
      $display("FAIL abort_outputs: got %h expected %h", {db_rb_idle, db_rb_req, db_rb_addr,
               db_rb_data, db_rb_rd_done, bst_req, bst_rw, bst_len, bst_wvalid, bst_wdata},
               {1'b1, 38'b0});
    end
    exp_q = {8'hC1, 8'hC2, 8'hC3, 8'h5A};
    foreach (exp_q[k]) begin
      checks++;
      if (bank[k] !== exp_q[k]) begin
        errors++; $display("FAIL abort_bank[%0d]: got %h expected %h", k, bank[k], exp_q[k]);
      end
    end
    checks++;
    if (rd_done_cnt != 0 || wdata_log.size() != 0 || hdr_log.size() != 1) begin
      errors++; $display("FAIL restart_ignored: got %0d rd_done %0d wbeats %0d headers expected 0 0 1",
                         rd_done_cnt, wdata_log.size(), hdr_log.size());
    end
    rd_src_q.delete();
    rst_n = 1'b1;
    @(negedge clk);
    wpat[0] = 1; wpat_n = 1;
    run_xfer(1'b1, 8'd2, 8'd2, 0, 0, 0);
    exp_q = {8'hC1, 8'hC2};
    checks++;
    if (timed_out || wdata_log != exp_q || hdr_log.size() != 1) begin
      errors++; $display("FAIL post_reset_run: got %0d beats %0d headers timeout %0d expected 2 1 0",
                         wdata_log.size(), hdr_log.size(), timed_out);
    end
  endtask

  // ---------------- sequence and report ----------------
  initial begin
    for (int i = 0; i < 256; i++) bank[i] = 8'h00;
    test_reset();
    test_write_split();
    test_read_in();
    test_boundaries();
    test_stall_and_gnt_delay();
    test_restart_and_abort();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got no completion expected finish before 200000");
    $fatal(1, "watchdog expired");
  end

endmodule
